// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache (port 0) and D-cache (port 1) onto one line-wide
// memory bus; the winning request is latched and held until mem_ack_i.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic              mem_enable_reg, mem_enable_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_data_reg, mem_data_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic              err_reg, err_next;
    logic              rr_winner, rr_valid;
    logic [1:0]        ack_vec;

    mem_arb_rr u_rr (
        .req0       (p0_enable_i),
        .req1       (p1_enable_i),
        .last_grant (last_grant_reg),
        .winner     (rr_winner),
        .valid      (rr_valid)
    );

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        wd_next         = wd_reg;
        err_next        = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rr_valid) begin
                    state_next      = ST_GRANT;
                    grant_next      = rr_winner;
                    last_grant_next = rr_winner;
                    mem_enable_next = 1'b1;
                    mem_write_next  = rr_winner ? p1_write_i : p0_write_i;
                    mem_addr_next   = rr_winner ? p1_addr_i  : p0_addr_i;
                    mem_data_next   = rr_winner ? p1_data_i  : p0_data_i;
                    wd_next         = '0;
                end
            end
            ST_GRANT: begin
                if (mem_ack_i) begin
                    state_next      = ST_GAP;
                    mem_enable_next = 1'b0;
                    mem_write_next  = 1'b0;
                end else if (wd_reg != WD_W'(TIMEOUT)) begin
                    // Watchdog only flags a stuck memory; the grant stays put.
                    wd_next = wd_reg + 1'b1;
                    if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= PORT_I;
            last_grant_reg <= PORT_D;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            wd_reg         <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            wd_reg         <= wd_next;
            err_reg        <= err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == ST_GRANT) && mem_ack_i && (grant_reg == 1'(gi));
        end
    endgenerate

    assign p0_ack_o     = ack_vec[0];
    assign p1_ack_o     = ack_vec[1];
    assign p0_data_o    = mem_data_i;
    assign p1_data_o    = mem_data_i;
    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;
    assign busy_o       = (state_reg == ST_GRANT);
    assign err_o        = err_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 256-bit data memory between the instruction-side cache (port 0) and the data cache (port 1). It uses round-robin priority and holds each grant until the memory acknowledges. The arbiter latches the winning request and drives the memory bus from registers. It returns the memory acknowledge only to the granted requester. Both requesters use the same level-hold enable/ack protocol as the memory.

## Interface
- ADDR_W, 32, memory byte-address width
- DATA_W, 256, cache-line width
- TIMEOUT, 64, cycles after which a grant with no acknowledge raises err_o
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset, asynchronous, active-low
- p0_enable_i / p1_enable_i  in  1  request; held high until that port's ack
- p0_write_i / p1_write_i  in  1  1 = write line, 0 = read line
- p0_addr_i / p1_addr_i  in  ADDR_W  line address
- p0_data_i / p1_data_i  in  DATA_W  write line
- p0_ack_o / p1_ack_o  out  1  completion for that port
- p0_data_o / p1_data_o  out  DATA_W  read line (mem_data_i fanned out to both)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion
- busy_o  out  1  high in GRANT state
- err_o  out  1  sticky timeout flag

## Operation
- States:
  - IDLE: no grant.
  - GRANT: a request is latched and mem_enable_o = 1.
  - GAP: one-cycle turnaround.
- IDLE, no enable high: stay in IDLE.
- IDLE, one or both enables high:
  - Choose the winner. With a single requester, it wins. With both, the port != last_grant wins.
  - Latch the winner's write/addr/data into mem_*_o; set grant and last_grant to the winner; mem_enable_o <= 1; go to GRANT.
- GRANT:
  - pK_ack_o = mem_ack_i & (grant == K), combinational. The other port's ack stays 0.
  - On mem_ack_i: mem_enable_o <= 0, mem_write_o <= 0, go to GAP.
  - Latched mem_addr_o / mem_data_o / mem_write_o do not change while in GRANT, even if the requester's inputs change.
- GAP: unconditionally go to IDLE. This lets the acknowledged requester drop or change its enable before re-arbitration.
- A requester that moves from write-back to refill keeps enable high but changes write/addr. It re-arbitrates in IDLE like any new request and may lose to the other port.
- Watchdog:
  - Counter cleared on entry to GRANT; increments each GRANT cycle without ack.
  - Saturating; on reaching TIMEOUT, err_o <= 1, sticky until reset.
  - The grant is not aborted.
- pK_data_o = mem_data_i always. A requester must qualify it with its own ack.

## Timing
- Reset values: state = IDLE; mem_enable_o, mem_write_o = 0; mem_addr_o, mem_data_o = 0; grant = 0; last_grant = 1 (port 0 wins the first tie); busy_o = 0; err_o = 0; watchdog = 0. Acks are 0 because the state is not GRANT.
- Request sampled at posedge N in IDLE: mem_enable_o high after edge N.
- mem_ack_i high during cycle M: pK_ack_o high the same cycle; mem_enable_o low after edge M; GAP during M+1; IDLE from M+2.
- Minimum spacing between consecutive grants is 2 cycles after ack. Back-to-back contention therefore alternates ports.
- mem_ack_i outside GRANT is ignored and produces no port ack.
- Reset mid-grant: the bus is dropped immediately and no ack is delivered. Requesters are reset by the same rst_i.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE / GRANT / GAP, 2-bit);
  - port id constants PORT_I = 0, PORT_D = 1;
  - default TIMEOUT.
- Sub-module mem_arb_rr: 2-way round-robin pick from (req0, req1, last_grant) → winner, valid.
- The FSM, output latch, and watchdog live in mem_arbiter.

## Test plan
- Only p1 reads addr 0x0000_0400, memory acks 10 cycles later: mem_addr_o = 0x400, mem_write_o = 0; p1_ack_o pulses exactly once; p0_ack_o stays 0; return to IDLE 2 cycles later.
- p0 and p1 both request in the same cycle after reset: p0 is granted first. After p0's ack, p1 is granted in the IDLE cycle following GAP.
- Continuous contention over 6 transactions: grant order is 0, 1, 0, 1, 0, 1.
- p1 changes addr from 0x400 to 0x800 mid-GRANT: mem_addr_o stays 0x400 until ack.
- p1 write-back (write = 1, addr A) then refill (write = 0, addr B) with enable held high: two separate grants; mem_write_o = 1 then 0; one ack per phase.
- No ack for 64 cycles: err_o rises at cycle 64 and stays high. rst_i asserted low mid-grant: mem_enable_o and err_o = 0 immediately.
